// File: rtl/mips_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding,
// owner encoding used by mem_sel and the last-owner register, default latency.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int MEM_LAT_DEF = 2;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data requesters.
// gnt[0] = fetch wins, gnt[1] = data wins; at most one bit is ever set.
// Macro MEM_ARB_RR_EN: defined selects round-robin on a tie (the requester that
// was not the last owner wins); undefined selects fixed priority, data first.
module mem_arb_pick
  import mips_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_own,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
  // Tie goes to whoever did not own the port last; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    if (i_req && d_req) begin
      if (last_own == OWN_D) gnt[0] = 1'b1;
      else                   gnt[1] = 1'b1;
    end else if (d_req) begin
      gnt[1] = 1'b1;
    end else if (i_req) begin
      gnt[0] = 1'b1;
    end
  end
`else
  // Fixed priority ignores history, so the last owner is deliberately dropped.
  logic unused_last_own;
  assign unused_last_own = last_own;

  // Data always beats fetch.
  always_comb begin
    gnt = 2'b00;
    if (d_req)      gnt[1] = 1'b1;
    else if (i_req) gnt[0] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// One transaction at a time: grant in IDLE, MEM_LAT cycles of ACCESS, one
// cycle of RESP carrying the owner's rvalid. Tie-break policy is chosen by
// the MEM_ARB_RR_EN macro inside mem_arb_pick.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e       state;
  arb_state_e       next_state;
  logic [CNT_W-1:0] cnt;
  logic             last_own;
  logic [1:0]       pick;
  logic             grant;
  logic             cnt_done;

  // Grants are only possible in IDLE and never while reset is held.
  mem_arb_pick u_pick (
    .i_req    (i_req & (state == IDLE) & ~rst),
    .d_req    (d_req & (state == IDLE) & ~rst),
    .last_own (last_own),
    .gnt      (pick)
  );

  assign i_gnt    = pick[0];
  assign d_gnt    = pick[1];
  assign grant    = pick[0] | pick[1];
  assign cnt_done = (cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant)    next_state = ACCESS;
      ACCESS:  if (cnt_done) next_state = RESP;
      RESP:                  next_state = IDLE;
      default:               next_state = IDLE;
    endcase
  end

  // State-decoded outputs; rvalid is steered by the registered owner (mem_sel).
  always_comb begin
    mem_en   = (state == ACCESS);
    busy     = (state != IDLE);
    i_rvalid = (state == RESP) && (mem_sel == OWN_I);
    d_rvalid = (state == RESP) && (mem_sel == OWN_D);
  end

  // Latency counter: loaded on grant, counts down through ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE && grant) begin
      cnt <= CNT_W'(MEM_LAT - 1);
    end else if (state == ACCESS && !cnt_done) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Access request registers, held stable from grant until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= OWN_I;
    end else if (grant) begin
      mem_addr  <= d_gnt ? d_addr  : i_addr;
      mem_wdata <= d_gnt ? d_wdata : '0;
      mem_we    <= d_gnt & d_we;
      mem_sel   <= d_gnt ? OWN_D : OWN_I;
    end
  end

  // Read data capture on the last ACCESS cycle; stores leave rdata untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (state == ACCESS && cnt_done && !mem_we) begin
      rdata <= mem_rdata;
    end
  end

  // Last owner for round-robin; starts at data so the first tie goes to fetch.
  always_ff @(posedge clk) begin
    if (rst)        last_own <= OWN_D;
    else if (grant) last_own <= d_gnt ? OWN_D : OWN_I;
  end

endmodule
